// File: rtl/lpc_pkg.sv
// lpc_pkg -- shared definitions for the LPC inverse-filter datapath.
//   LPC_ORDER     : default predictor order (taps 0..ORDER)
//   LPC_FRAME_LEN : default samples per frame
//   LPC_ADDR_W    : default sample/residue address width
//   seq_state_t   : sequencer FSM state encoding
package lpc_pkg;
  localparam int LPC_ORDER     = 10;
  localparam int LPC_FRAME_LEN = 240;
  localparam int LPC_ADDR_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TAP   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;
endpackage

// File: rtl/ifilter_sequencer.sv
// ifilter_sequencer -- address/control sequencer for an LPC inverse filter.
// For each sample n of a frame it walks taps k=0..ORDER (one cycle each),
// then issues one residue write at address n.
// Ports:
//   clk, reset (sync, active low)   clock / reset
//   start                           frame request (honoured only when idle)
//   stall                           back-pressure, freezes TAP/WRITE
//   x_raddr, x_zero                 sample read address n-k / zero operand (n<k)
//   a_rsel                          one-hot coefficient select (bit k-1)
//   tap_first                       k==0, accumulator clear
//   residue_waddr, residue_wen      residue write port
//   next_sample                     sample-complete pulse
//   ready, done                     idle flag / frame-end pulse
module ifilter_sequencer
  import lpc_pkg::*;
#(
  parameter int ORDER     = LPC_ORDER,
  parameter int FRAME_LEN = LPC_FRAME_LEN,
  parameter int ADDR_W    = LPC_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic [ADDR_W-1:0] x_raddr,
  output logic              x_zero,
  output logic [ORDER-1:0]  a_rsel,
  output logic              tap_first,
  output logic [ADDR_W-1:0] residue_waddr,
  output logic              residue_wen,
  output logic              next_sample,
  output logic              ready,
  output logic              done
);
  localparam int              K_W    = $clog2(ORDER + 1);
  localparam logic [K_W-1:0]  K_LAST = K_W'(ORDER);
  localparam logic [ADDR_W-1:0] N_LAST = ADDR_W'(FRAME_LEN - 1);

  seq_state_t        r_state;
  logic [ADDR_W-1:0] r_n;
  logic [K_W-1:0]    r_k;

  logic [ADDR_W-1:0] w_k_ext;
  logic              w_in_frame;
  logic              w_tap;
  logic              w_write;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_k     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_TAP;
          r_n     <= '0;
          r_k     <= '0;
        end
        S_TAP: if (!stall) begin
          if (r_k == K_LAST) r_state <= S_WRITE;
          else               r_k     <= r_k + 1'b1;
        end
        S_WRITE: if (!stall) begin
          r_k <= '0;
          if (r_n == N_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_n     <= r_n + 1'b1;
            r_state <= S_TAP;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_n     <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state so stall can mask the write strobe
  // in the same cycle; reset also gates them so the reset cycle is clean.
  assign w_k_ext    = ADDR_W'(r_k);
  assign w_in_frame = (r_n >= w_k_ext);
  assign w_tap      = reset && (r_state == S_TAP);
  assign w_write    = reset && (r_state == S_WRITE);

  assign x_zero        = w_tap && !w_in_frame;
  assign x_raddr       = (w_tap && w_in_frame) ? (r_n - w_k_ext) : '0;
  assign a_rsel        = (w_tap && (r_k != '0)) ? (ORDER'(1) << (r_k - 1'b1)) : '0;
  assign tap_first     = w_tap && (r_k == '0);
  assign residue_waddr = w_write ? r_n : '0;
  assign residue_wen   = w_write && !stall;
  assign next_sample   = w_write && !stall;
  assign ready         = !reset || (r_state == S_IDLE);
  assign done          = reset && (r_state == S_DONE);
endmodule

// File: tb/tb_ifilter_sequencer.sv
module tb_ifilter_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic       rst_n, start, stall;
  logic [7:0] x_raddr, waddr;
  logic       x_zero, tap_first, wen, nsamp, ready, done;
  logic [9:0] a_rsel;

  // ORDER=4, FRAME_LEN=16 instance
  logic       s_rst_n, s_start, s_stall;
  logic [7:0] s_x_raddr, s_waddr;
  logic       s_x_zero, s_tap_first, s_wen, s_nsamp, s_ready, s_done;
  logic [3:0] s_a_rsel;

  ifilter_sequencer u_dut (
    .clk(clk), .reset(rst_n), .start(start), .stall(stall),
    .x_raddr(x_raddr), .x_zero(x_zero), .a_rsel(a_rsel), .tap_first(tap_first),
    .residue_waddr(waddr), .residue_wen(wen), .next_sample(nsamp),
    .ready(ready), .done(done));

  ifilter_sequencer #(.ORDER(4), .FRAME_LEN(16), .ADDR_W(8)) u_small (
    .clk(clk), .reset(s_rst_n), .start(s_start), .stall(s_stall),
    .x_raddr(s_x_raddr), .x_zero(s_x_zero), .a_rsel(s_a_rsel), .tap_first(s_tap_first),
    .residue_waddr(s_waddr), .residue_wen(s_wen), .next_sample(s_nsamp),
    .ready(s_ready), .done(s_done));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // per-frame statistics
  int first_c, first_a, last_c, last_a, nwr, done_c, ndone, w7;

  // Run one frame on the default instance; cycle c=0 presents start.
  // Negative arguments disable the corresponding event.
  task automatic run_big(input bit pad, input int stall_at, input int start_at,
                         input int rst_at);
    int k;
    first_c = -1; first_a = -1; last_c = -1; last_a = -1;
    nwr = 0; done_c = -1; ndone = 0; w7 = 0;
    for (int c = 0; c <= 3000; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (c == start_at);
      stall = (stall_at >= 0) && (c >= stall_at) && (c < stall_at + 5);
      rst_n = !(c == rst_at);
      #1;
      if (c == rst_at) begin
        chk("rst_cycle_wen", wen, 0);
        chk("rst_cycle_ready", ready, 1);
        continue;
      end
      if (rst_at >= 0 && c == rst_at + 1) begin
        chk("after_rst_ready", ready, 1);
        chk("after_rst_wen", wen, 0);
        chk("after_rst_xzero", x_zero, 0);
        return;
      end
      if (wen) begin
        if (first_c < 0) begin first_c = c; first_a = waddr; end
        last_c = c; last_a = waddr; nwr++;
        if (waddr == 7) w7++;
        if (nsamp !== 1'b1) chk("nsamp_with_wen", nsamp, 1);
      end
      if (stall) begin
        chk("stall_wen", wen, 0);
        chk("stall_nsamp", nsamp, 0);
        chk("stall_waddr", waddr, 7);
      end
      if (pad && c >= 37 && c <= 47) begin
        k = c - 37;
        chk("pad_raddr", x_raddr, (k <= 3) ? 3 - k : 0);
        chk("pad_xzero", x_zero, (k > 3) ? 1 : 0);
        chk("pad_tapfirst", tap_first, (k == 0) ? 1 : 0);
        if (k == 4) chk("pad_arsel_k4", a_rsel, 10'b0000001000);
      end
      if (done) begin
        if (done_c < 0) done_c = c;
        ndone++;
        chk("done_arsel", a_rsel, 0);
        chk("done_ready", ready, 0);
      end
      if (done_c >= 0 && c == done_c + 1) begin
        chk("post_done_ready", ready, 1);
        chk("post_done_done", done, 0);
        return;
      end
    end
    chk("timeout", 1, 0);
  endtask

  int sw[$];
  int s_done_c, s_last_a;

  initial begin
    rst_n = 0; start = 0; stall = 0;
    s_rst_n = 0; s_start = 0; s_stall = 0;
    repeat (2) @(posedge clk);
    #1; start = 1; stall = 1; #1;
    chk("rst_ready", ready, 1);
    chk("rst_wen", wen, 0);
    chk("rst_done", done, 0);
    chk("rst_arsel", a_rsel, 0);
    chk("rst_raddr", x_raddr, 0);
    chk("rst_small_ready", s_ready, 1);
    @(posedge clk); #1;
    rst_n = 1; s_rst_n = 1; start = 0; stall = 0; #1;
    chk("idle_ready", ready, 1);
    chk("idle_tapfirst", tap_first, 0);

    // nominal frame with zero-padding checks
    run_big(1, -1, -1, -1);
    chk("f1_first_c", first_c, 12);
    chk("f1_first_a", first_a, 0);
    chk("f1_last_c", last_c, 2880);
    chk("f1_last_a", last_a, 239);
    chk("f1_done_c", done_c, 2881);
    chk("f1_nwr", nwr, 240);
    chk("f1_ndone", ndone, 1);

    // stall over the WRITE of n=7 (WRITE of n is at c=12*(n+1))
    run_big(0, 96, -1, -1);
    chk("st_w7", w7, 1);
    chk("st_nwr", nwr, 240);
    chk("st_done_c", done_c, 2886);

    // reset mid-frame at n=100, k=4
    run_big(0, -1, -1, 1205);
    chk("rs_nwr", nwr, 100);

    // replay from n=0 with a stray start at n=50
    run_big(0, -1, 601, -1);
    chk("rp_first_c", first_c, 12);
    chk("rp_first_a", first_a, 0);
    chk("rp_done_c", done_c, 2881);
    chk("rp_nwr", nwr, 240);
    chk("rp_ndone", ndone, 1);
    start = 0;

    // small instance: ORDER=4, FRAME_LEN=16
    s_done_c = -1; s_last_a = -1;
    for (int c = 0; c <= 150; c++) begin
      @(posedge clk); #1;
      s_start = (c == 0); #1;
      if (s_wen) begin sw.push_back(c); s_last_a = s_waddr; end
      if (c == 5) chk("sm_arsel_k4", s_a_rsel, 4'b1000);
      if (c == 1) chk("sm_tapfirst", s_tap_first, 1);
      if (s_done && s_done_c < 0) s_done_c = c;
    end
    chk("sm_nwr", sw.size(), 16);
    if (sw.size() >= 2) begin
      chk("sm_first_c", sw[0], 6);
      chk("sm_second_c", sw[1], 12);
    end
    chk("sm_last_a", s_last_a, 15);
    chk("sm_done_c", s_done_c, 97);
    chk("sm_ready_end", s_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifilter_sequencer.md
IFILTER_SEQUENCER -- requirements
Module: ifilter_sequencer

Interface
REQ-001 SHALL have parameter ORDER, default 10: LPC predictor order; taps k = 0..ORDER.
REQ-002 SHALL have parameter FRAME_LEN, default 240: samples per frame, legal range 2..2**ADDR_W.
REQ-003 SHALL have parameter ADDR_W, default 8: sample and residue address width.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: frame request, sampled only in IDLE.
REQ-007 SHALL have port stall, input, 1: downstream back-pressure that freezes sequencing.
REQ-008 SHALL have port x_raddr, output, ADDR_W: sample-buffer read address, n-k.
REQ-009 SHALL have port x_zero, output, 1: current tap precedes the frame start (n<k), so the MAC uses operand 0.
REQ-010 SHALL have port a_rsel, output, ORDER: one-hot coefficient select, bit k-1 for tap k>=1, all-zero for tap 0 (unity coefficient).
REQ-011 SHALL have port tap_first, output, 1: tap k=0 is active, so the accumulator clears.
REQ-012 SHALL have port residue_waddr, output, ADDR_W: residue write address, n.
REQ-013 SHALL have port residue_wen, output, 1: residue write strobe.
REQ-014 SHALL have port next_sample, output, 1: one-cycle pulse marking sample completion.
REQ-015 SHALL have port ready, output, 1: idle, start accepted.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at frame end.

Function
REQ-017 SHALL implement FSM states IDLE, TAP, WRITE and DONE.
REQ-018 SHALL move IDLE->TAP when start=1 is sampled in cycle t; the first TAP cycle is t+1, with n=0 and k=0.
REQ-019 SHALL, in TAP, hold each tap k for one non-stalled cycle, k incrementing 0..ORDER; after k=ORDER, the next state is WRITE.
REQ-020 SHALL drive x_raddr=n-k and x_zero=0 in TAP when n>=k; otherwise x_raddr=0 and x_zero=1.
REQ-021 SHALL, in WRITE, assert residue_wen=1, residue_waddr=n and next_sample=1 for exactly one non-stalled cycle.
REQ-022 SHALL, after WRITE, return to TAP with n+1 and k=0 if n<FRAME_LEN-1; otherwise it SHALL enter DONE.
REQ-023 SHALL, in DONE, assert done=1 for one cycle and then return to IDLE.
REQ-024 SHALL take ORDER+2 cycles per sample with stall=0; done SHALL be asserted at cycle t+1+FRAME_LEN*(ORDER+2).
REQ-025 SHALL, while stall=1 in TAP or WRITE, freeze the state, n, k and all address outputs, and force residue_wen=0 and next_sample=0.
REQ-026 SHALL ignore stall in IDLE and DONE.
REQ-027 SHALL ignore start outside IDLE, with no queuing.
REQ-028 SHALL assert ready=1 only in IDLE.
REQ-029 SHALL keep a_rsel, tap_first and x_zero at 0 outside TAP.
REQ-030 SHALL size counters to hold FRAME_LEN-1 and ORDER with no wrap; n SHALL never exceed FRAME_LEN-1.

Reset
REQ-031 SHALL, when reset=0 is sampled, enter IDLE on the next edge, even mid-frame.
REQ-032 SHALL set n=0 and k=0 in reset.
REQ-033 SHALL drive all outputs to 0 in reset, except ready=1.
REQ-034 SHALL make reset override start and stall.
REQ-035 SHALL NOT issue a residue write in the cycle reset is sampled.

Structure
REQ-036 SHALL take the ORDER, FRAME_LEN and ADDR_W defaults and the state enum from shared package lpc_pkg.
REQ-037 SHALL be a single module; counters and the FSM are inline, with no sub-module.

Verification
REQ-038 SHALL verify the defaults frame: start pulse at t -> first residue_wen at t+12 with waddr=0; last residue_wen at t+2880 with waddr=239; done at t+2881; exactly 240 writes.
REQ-039 SHALL verify zero padding: at n=3, taps k=0..3 give x_raddr=3,2,1,0 with x_zero=0; taps k=4..10 give x_zero=1; a_rsel for k=4 is 10'b0000001000.
REQ-040 SHALL verify stall: stall=1 for 5 cycles during the WRITE of n=7 -> residue_wen stays 0 and outputs hold; one write to address 7 occurs after release; done is delayed 5 cycles.
REQ-041 SHALL verify reset mid-frame: reset=0 at n=100 -> next cycle IDLE with ready=1 and residue_wen=0; a new start replays from n=0.
REQ-042 SHALL verify start while busy: start pulses at n=50 -> no effect, and done still occurs at t+2881.
REQ-043 SHALL verify parameters ORDER=4, FRAME_LEN=16: 6 cycles per sample, done at t+97, and a_rsel is 4 bits.
